mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter in front of one single-port synchronous RAM
//
// Optional feature macro: MEM_ARB_LOCK_EN (adds cpu_lock and the LOCKED state)
//
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata         CPU request, held until cpu_gnt
//   cpu_lock                      (MEM_ARB_LOCK_EN only) keep I/O out after a locked grant
//   cpu_gnt, cpu_rvalid, cpu_rdata CPU grant, read-return pulse, registered read data
//   io_*                          same set for the I/O requester
//   mem_addr/wdata/we, mem_rdata  RAM side; mem_rdata valid the cycle after the address

module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic              cpu_lock,
`endif
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lock_hold;
    logic       io_turn;
    logic       cpu_rd_p1;
    logic       io_rd_p1;

    // The lock only excludes I/O while cpu_lock is still high; the cycle it
    // drops already arbitrates normally.
`ifdef MEM_ARB_LOCK_EN
    assign lock_hold = (state == LOCKED) && cpu_lock;
`else
    assign lock_hold = (state == LOCKED);
`endif

    assign io_turn = (wait_cnt == MAX_WAIT_C);

    // Grants are gated by reset so nothing reaches the RAM while it is held.
    always_comb begin
        cpu_gnt = 1'b0;
        io_gnt  = 1'b0;
        if (reset) begin
            if (io_req && !lock_hold && (!cpu_req || io_turn)) begin
                io_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    // With no grant the RAM port idles on the CPU's address and data.
    always_comb begin
        mem_addr  = io_gnt ? io_addr  : cpu_addr;
        mem_wdata = io_gnt ? io_wdata : cpu_wdata;
        mem_we    = (cpu_gnt && cpu_we) || (io_gnt && io_we);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ARB;
        end else begin
`ifdef MEM_ARB_LOCK_EN
            case (state)
                ARB:     if (cpu_gnt && cpu_lock) state <= LOCKED;
                LOCKED:  if (!cpu_lock) state <= ARB;
                default: state <= ARB;
            endcase
`else
            state <= ARB;
`endif
        end
    end

    // Counts consecutive cycles I/O asked and was refused; saturates so that
    // I/O keeps winning priority until it is actually served.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
        end else if (!io_req || io_gnt) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt < MAX_WAIT_C) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Read return: grant in T, RAM data in T+1 captured at its end, rvalid in T+2.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_rd_p1  <= 1'b0;
            io_rd_p1   <= 1'b0;
            cpu_rvalid <= 1'b0;
            io_rvalid  <= 1'b0;
            cpu_rdata  <= '0;
            io_rdata   <= '0;
        end else begin
            cpu_rd_p1  <= cpu_gnt && !cpu_we;
            io_rd_p1   <= io_gnt && !io_we;
            cpu_rvalid <= cpu_rd_p1;
            io_rvalid  <= io_rd_p1;
            if (cpu_rd_p1) cpu_rdata <= mem_rdata;
            if (io_rd_p1)  io_rdata  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter against a rule-level model

module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    logic        cpu_lock = 1'b0;
`endif
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        io_req = 1'b0, io_we = 1'b0;
    logic [15:0] io_addr = '0, io_wdata = '0;
    logic        io_gnt, io_rvalid;
    logic [15:0] io_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef MEM_ARB_LOCK_EN
        .cpu_lock(cpu_lock),
`endif
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Single-port synchronous RAM, read-first.
    logic [15:0] ram [0:65535];
    always @(posedge clock) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    // Reference model state
    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    rsp_t        cpu_q[$];
    rsp_t        io_q[$];
    logic [15:0] ref_wr [logic [15:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          io_denied = 0;
    bit          m_locked = 0;
    bit          last_cg = 0, last_ig = 0;
    logic [15:0] exp_crdata = '0, exp_irdata = '0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_wr.exists(a)) return ref_wr[a];
        return init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: predict from the arbitration rules, compare, advance the model.
    task automatic step();
        bit          e_cg, e_ig, e_crv, e_irv, hold, e_we;
        logic [15:0] e_addr, e_wdata;
        @(negedge clock);
        e_cg = 0; e_ig = 0; e_crv = 0; e_irv = 0; hold = 0;
        if (!reset) begin
            cpu_q.delete();
            io_q.delete();
            io_denied  = 0;
            m_locked   = 0;
            exp_crdata = '0;
            exp_irdata = '0;
        end else begin
`ifdef MEM_ARB_LOCK_EN
            hold = m_locked && cpu_lock;
`endif
            if (cpu_req && io_req) begin
                if (!hold && io_denied == MAX_WAIT) e_ig = 1;
                else e_cg = 1;
            end else if (cpu_req) begin
                e_cg = 1;
            end else if (io_req && !hold) begin
                e_ig = 1;
            end
            if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
                e_crv = 1;
                exp_crdata = cpu_q[0].data;
                void'(cpu_q.pop_front());
            end
            if (io_q.size() > 0 && io_q[0].due == cyc) begin
                e_irv = 1;
                exp_irdata = io_q[0].data;
                void'(io_q.pop_front());
            end
        end
        e_addr  = e_ig ? io_addr : cpu_addr;
        e_wdata = e_ig ? io_wdata : cpu_wdata;
        e_we    = (e_cg && cpu_we) || (e_ig && io_we);

        chk("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, e_cg});
        chk("io_gnt", {31'd0, io_gnt}, {31'd0, e_ig});
        chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e_crv});
        chk("io_rvalid", {31'd0, io_rvalid}, {31'd0, e_irv});
        chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, exp_crdata});
        chk("io_rdata", {16'd0, io_rdata}, {16'd0, exp_irdata});
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_wdata});

        if (reset) begin
            if (e_cg) begin
                if (cpu_we) ref_wr[cpu_addr] = cpu_wdata;
                else cpu_q.push_back('{due: cyc + 2, data: ref_rd(cpu_addr)});
            end
            if (e_ig) begin
                if (io_we) ref_wr[io_addr] = io_wdata;
                else io_q.push_back('{due: cyc + 2, data: ref_rd(io_addr)});
            end
            if (io_req && !e_ig) io_denied = (io_denied < MAX_WAIT) ? io_denied + 1 : io_denied;
            else io_denied = 0;
`ifdef MEM_ARB_LOCK_EN
            if (m_locked && !cpu_lock) m_locked = 0;
            else if (!m_locked && e_cg && cpu_lock) m_locked = 1;
`endif
        end
        last_cg = e_cg;
        last_ig = e_ig;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_req = 0;
        io_req  = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));

        // Reset state, then requests raised while still in reset
        step();
        cpu_req = 1; io_req = 1; cpu_addr = 16'h0001; io_addr = 16'h0002;
        step();
        reset = 1;
        idle(2);

        // Reset in the middle of a read
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        step();
        reset = 0; cpu_req = 0;
        step();
        cpu_req = 1; io_req = 1;
        step();
        reset = 1;
        idle(3);
        chk("reset_flush_rdata", {16'd0, cpu_rdata}, 32'd0);

        // Solo CPU: write then read-after-write
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0004; cpu_wdata = 16'hBEEF;
        step();
        cpu_we = 0;
        step();
        idle(3);
        chk("cpu_raw_beef", {16'd0, cpu_rdata}, 32'h0000BEEF);

        // Solo I/O: back-to-back reads
        io_req = 1; io_we = 0; io_addr = 16'h0100;
        step();
        io_addr = 16'h0101;
        step();
        idle(3);
        chk("io_b2b_last", {16'd0, io_rdata}, {16'd0, init_val(16'h0101)});

        // Contention: four CPU grants then one I/O grant, repeating
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        io_req = 1; io_we = 0; io_addr = 16'h0050;
        for (int i = 0; i < 15; i++) step();
        idle(3);

        // I/O request dropped before grant, then the wait restarts from zero
        cpu_req = 1; io_req = 1; io_addr = 16'h0060;
        step();
        step();
        io_req = 0;
        step();
        io_req = 1;
        for (int i = 0; i < 6; i++) step();
        idle(3);

`ifdef MEM_ARB_LOCK_EN
        // Locked read-modify-write keeps I/O out until cpu_lock falls
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020; cpu_lock = 1;
        io_req = 1; io_we = 0; io_addr = 16'h0030;
        step();
        cpu_req = 0;
        for (int i = 0; i < 10; i++) step();
        cpu_lock = 0;
        step();
        idle(3);
`endif

        // Randomized traffic honouring hold-until-grant
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 149) != 0);
            if (!cpu_req || last_cg) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'($urandom_range(0, 15));
                cpu_wdata = 16'($urandom);
            end
            if (io_req && !last_ig && $urandom_range(0, 7) == 0) begin
                io_req = 0;
            end else if (!io_req || last_ig) begin
                io_req   = ($urandom_range(0, 2) != 0);
                io_we    = 1'($urandom_range(0, 1));
                io_addr  = 16'($urandom_range(0, 15));
                io_wdata = 16'($urandom);
            end
`ifdef MEM_ARB_LOCK_EN
            cpu_lock = ($urandom_range(0, 5) == 0);
`endif
            step();
        end
        reset = 1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
